// File: rtl/alto_ctl_pkg.sv
// rtl/alto_ctl_pkg.sv - shared constants, types and helpers for the Alto control store blocks
//
// Purpose : common definitions for the per-task micro-PC bank and its init walker.
// Contents: clog2/task_width helpers, default geometry, task index type, walker states.
package alto_ctl_pkg;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Task index width never drops below one bit so a 1-bit bus always exists.
  function automatic int task_width(input int num_tasks);
    return (clog2(num_tasks) < 1) ? 1 : clog2(num_tasks);
  endfunction

  localparam int DEFAULT_NUM_TASKS = 16;
  localparam int DEFAULT_PC_WIDTH  = 12;
  localparam int DEFAULT_BANK_BIT  = 10;
  localparam int DEFAULT_TW        = task_width(DEFAULT_NUM_TASKS);

  typedef logic [DEFAULT_TW-1:0] task_idx_t;

  typedef enum logic {
    WALK_IDLE = 1'b0,
    WALK_RUN  = 1'b1
  } walk_state_t;

endpackage

// File: rtl/alto_task_mpc_bank_if.sv
// rtl/alto_task_mpc_bank_if.sv - task/MPC bus between the microsequencer and the MPC bank
//
// Purpose : groups every non-clock/reset signal of alto_task_mpc_bank.
// Modports: slave  - the bank (consumes rmr/reinit/stall/task/mpc/dbg, drives status and reads)
//           master - the sequencer or bench driving the bank
interface alto_task_mpc_bank_if #(
  parameter int NUM_TASKS = 16,
  parameter int PC_WIDTH  = 12
);
  import alto_ctl_pkg::*;

  localparam int TW = task_width(NUM_TASKS);

  logic [NUM_TASKS-1:0] rmr_i;
  logic                 reinit_i;
  logic                 clear_rmr_o;
  logic                 initializing_o;
  logic                 stall_i;
  logic [TW-1:0]        task_i;
  logic [TW-1:0]        next_task_i;
  logic [PC_WIDTH-1:0]  mpc_i;
  logic [PC_WIDTH-1:0]  mpc_o;
  logic [TW-1:0]        dbg_task_i;
  logic [PC_WIDTH-1:0]  dbg_mpc_o;

  modport slave (
    input  rmr_i, reinit_i, stall_i, task_i, next_task_i, mpc_i, dbg_task_i,
    output clear_rmr_o, initializing_o, mpc_o, dbg_mpc_o
  );

  modport master (
    output rmr_i, reinit_i, stall_i, task_i, next_task_i, mpc_i, dbg_task_i,
    input  clear_rmr_o, initializing_o, mpc_o, dbg_mpc_o
  );

endinterface

// File: rtl/alto_task_init_walker.sv
// rtl/alto_task_init_walker.sv - boot/warm-restart walk sequencer for the task MPC bank
//
// Purpose : steps an index 0..NUM_TASKS-1 once after reset or on reinit_i, one entry per cycle.
// Ports   : clk_i, rst_i (async, active high)
//           reinit_i    - restart the walk from index 0 at the next edge
//           active_o    - walk in progress
//           idx_o       - entry being written this cycle
//           clear_rmr_o - high on the final walk cycle only
module alto_task_init_walker
  import alto_ctl_pkg::*;
#(
  parameter int NUM_TASKS = DEFAULT_NUM_TASKS,
  localparam int TW = task_width(NUM_TASKS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          reinit_i,
  output logic          active_o,
  output logic [TW-1:0] idx_o,
  output logic          clear_rmr_o
);

  localparam logic [TW-1:0] LAST_IDX = TW'(NUM_TASKS - 1);

  walk_state_t   state_q, state_d;
  logic [TW-1:0] idx_q, idx_d;
  logic          last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WALK_RUN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Terminal detect is qualified by the walk state so an idle index parked
  // at LAST_IDX never produces a spurious clear pulse.
  assign last = (state_q == WALK_RUN) && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (reinit_i) begin
      // Restart wins over completion; the final write and pulse of the
      // current cycle still happen because they are combinational.
      state_d = WALK_RUN;
      idx_d   = '0;
    end else if (state_q == WALK_RUN) begin
      if (last) begin
        state_d = WALK_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  assign active_o    = (state_q == WALK_RUN);
  assign idx_o       = idx_q;
  assign clear_rmr_o = last;

endmodule

// File: rtl/alto_task_mpc_bank.sv
// rtl/alto_task_mpc_bank.sv - per-task micro-PC context store with bypass, init walk and debug port
//
// Purpose : holds the saved MPC of every task, supplies the MPC for next_task_i, seeds all
//           entries from the RMR after reset or reinit, and offers a registered debug read.
// Ports   : clk_i, rst_i (async, active high)
//           bus (slave) - rmr_i, reinit_i, stall_i, task_i, next_task_i, mpc_i, dbg_task_i in;
//                         clear_rmr_o, initializing_o, mpc_o, dbg_mpc_o out
module alto_task_mpc_bank
  import alto_ctl_pkg::*;
#(
  parameter int                  NUM_TASKS = DEFAULT_NUM_TASKS,
  parameter int                  PC_WIDTH  = DEFAULT_PC_WIDTH,
  parameter int                  BANK_BIT  = DEFAULT_BANK_BIT,
  parameter logic [PC_WIDTH-1:0] BOOT_BASE = '0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  alto_task_mpc_bank_if.slave bus
);

  localparam int TW = task_width(NUM_TASKS);
  localparam logic [TW:0] NT_LIMIT = (TW + 1)'(NUM_TASKS);

  // Index codes at or above NUM_TASKS exist only for non-power-of-two counts.
  function automatic logic in_range(input logic [TW-1:0] idx);
    return {1'b0, idx} < NT_LIMIT;
  endfunction

  logic                walk_active;
  logic                walk_last;
  logic [TW-1:0]       walk_idx;
  logic                boot_bank;
  logic [PC_WIDTH-1:0] boot_mpc;
  logic                wr_en;
  logic [TW-1:0]       wr_idx;
  logic [PC_WIDTH-1:0] wr_data;
  logic [PC_WIDTH-1:0] mpc_rd;
  logic [PC_WIDTH-1:0] dbg_mpc_d, dbg_mpc_q;

  // Context array: no reset, contents are established by the walk.
  logic [PC_WIDTH-1:0] mem_q [NUM_TASKS];

  alto_task_init_walker #(
    .NUM_TASKS (NUM_TASKS)
  ) u_walker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .reinit_i    (bus.reinit_i),
    .active_o    (walk_active),
    .idx_o       (walk_idx),
    .clear_rmr_o (walk_last)
  );

  // Boot MPC: a clear RMR bit selects the upper bank.
  always_comb begin
    boot_bank = ~bus.rmr_i[walk_idx];
    boot_mpc  = BOOT_BASE | (PC_WIDTH'(boot_bank) << BANK_BIT) | PC_WIDTH'(walk_idx);
  end

  // Single write port shared by the walk and normal execution; the walk
  // ignores stall_i entirely.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (walk_active) begin
      wr_en   = 1'b1;
      wr_idx  = walk_idx;
      wr_data = boot_mpc;
    end else if (!bus.stall_i && in_range(bus.task_i)) begin
      wr_en   = 1'b1;
      wr_idx  = bus.task_i;
      wr_data = bus.mpc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Same-task bypass forwards the in-flight MPC so a task that keeps running
  // sees its new MPC with zero latency.
  always_comb begin
    mpc_rd = '0;
    if (in_range(bus.next_task_i)) begin
      if (!walk_active && !bus.stall_i && (bus.task_i == bus.next_task_i)) begin
        mpc_rd = bus.mpc_i;
      end else begin
        mpc_rd = mem_q[bus.next_task_i];
      end
    end
  end

  // Debug read samples the array before this edge's write lands.
  always_comb begin
    dbg_mpc_d = '0;
    if (in_range(bus.dbg_task_i)) begin
      dbg_mpc_d = mem_q[bus.dbg_task_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbg_mpc_q <= '0;
    end else begin
      dbg_mpc_q <= dbg_mpc_d;
    end
  end

  assign bus.mpc_o          = mpc_rd;
  assign bus.dbg_mpc_o      = dbg_mpc_q;
  assign bus.initializing_o = walk_active;
  assign bus.clear_rmr_o    = walk_last;

endmodule

// File: tb/tb_alto_task_mpc_bank.sv
// tb/tb_alto_task_mpc_bank.sv - self-checking bench for alto_task_mpc_bank (16x12 and 12x14 builds)
module tb_alto_task_mpc_bank;
  import alto_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alto_task_mpc_bank_if #(.NUM_TASKS(16), .PC_WIDTH(12)) bus_a ();
  alto_task_mpc_bank_if #(.NUM_TASKS(12), .PC_WIDTH(14)) bus_b ();

  alto_task_mpc_bank #(.NUM_TASKS(16), .PC_WIDTH(12), .BANK_BIT(10)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (bus_a.slave));
  alto_task_mpc_bank #(.NUM_TASKS(12), .PC_WIDTH(14), .BANK_BIT(12)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (bus_b.slave));

  // Shared stimulus
  logic        stall, reinit;
  task_idx_t   tsk, ntsk, dbg;
  logic [15:0] rmr_a;
  logic [11:0] rmr_b;
  logic [11:0] mpc_a;
  logic [13:0] mpc_b;

  assign bus_a.stall_i = stall;     assign bus_b.stall_i = stall;
  assign bus_a.reinit_i = reinit;   assign bus_b.reinit_i = reinit;
  assign bus_a.task_i = tsk;        assign bus_b.task_i = tsk;
  assign bus_a.next_task_i = ntsk;  assign bus_b.next_task_i = ntsk;
  assign bus_a.dbg_task_i = dbg;    assign bus_b.dbg_task_i = dbg;
  assign bus_a.rmr_i = rmr_a;       assign bus_b.rmr_i = rmr_b;
  assign bus_a.mpc_i = mpc_a;       assign bus_b.mpc_i = mpc_b;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: index 0 = 16-task build, index 1 = 12-task build.
  int unsigned m_mem [2][16];
  bit          m_val [2][16];
  bit          m_init [2];
  int          m_pos [2];
  int unsigned m_dbg [2];
  bit          m_dbg_val [2];

  function automatic int nt_of(input int d);   return (d == 0) ? 16 : 12; endfunction
  function automatic int bank_of(input int d); return (d == 0) ? 10 : 12; endfunction
  function automatic int unsigned mpc_in(input int d);
    return (d == 0) ? int'(mpc_a) : int'(mpc_b);
  endfunction
  function automatic bit rmr_bit(input int d, input int i);
    return (d == 0) ? rmr_a[i] : rmr_b[i];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_init[d] = 1'b1;
      m_pos[d] = 0;
      m_dbg[d] = 0;
      m_dbg_val[d] = 1'b1;
    end
  endtask

  task automatic model_update();
    int n, t, dq;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_init[d] = 1'b1; m_pos[d] = 0; m_dbg[d] = 0; m_dbg_val[d] = 1'b1;
        continue;
      end
      n = nt_of(d);
      dq = int'(dbg);
      if (dq >= n) begin
        m_dbg[d] = 0; m_dbg_val[d] = 1'b1;
      end else begin
        m_dbg[d] = m_mem[d][dq]; m_dbg_val[d] = m_val[d][dq];
      end
      if (m_init[d]) begin
        m_mem[d][m_pos[d]] = (rmr_bit(d, m_pos[d]) ? 0 : (1 << bank_of(d))) | m_pos[d];
        m_val[d][m_pos[d]] = 1'b1;
        if (reinit) m_pos[d] = 0;
        else if (m_pos[d] == n - 1) begin m_init[d] = 1'b0; m_pos[d] = 0; end
        else m_pos[d]++;
      end else begin
        t = int'(tsk);
        if (!stall && t < n) begin
          m_mem[d][t] = mpc_in(d); m_val[d][t] = 1'b1;
        end
        if (reinit) begin m_init[d] = 1'b1; m_pos[d] = 0; end
      end
    end
  endtask

  task automatic model_check();
    int n, nx;
    logic [31:0] g_init, g_clr, g_mpc, g_dbg;
    for (int d = 0; d < 2; d++) begin
      n = nt_of(d);
      nx = int'(ntsk);
      g_init = (d == 0) ? 32'(bus_a.initializing_o) : 32'(bus_b.initializing_o);
      g_clr  = (d == 0) ? 32'(bus_a.clear_rmr_o)    : 32'(bus_b.clear_rmr_o);
      g_mpc  = (d == 0) ? 32'(bus_a.mpc_o)          : 32'(bus_b.mpc_o);
      g_dbg  = (d == 0) ? 32'(bus_a.dbg_mpc_o)      : 32'(bus_b.dbg_mpc_o);
      chk($sformatf("dut%0d initializing", d), g_init, 32'(m_init[d]));
      chk($sformatf("dut%0d clear_rmr", d), g_clr, 32'(m_init[d] && m_pos[d] == n - 1));
      if (nx >= n) chk($sformatf("dut%0d mpc_oob", d), g_mpc, 0);
      else if (!m_init[d] && !stall && tsk == ntsk) chk($sformatf("dut%0d mpc_bypass", d), g_mpc, mpc_in(d));
      else if (m_val[d][nx]) chk($sformatf("dut%0d mpc_stored", d), g_mpc, m_mem[d][nx]);
      if (m_dbg_val[d]) chk($sformatf("dut%0d dbg_mpc", d), g_dbg, m_dbg[d]);
    end
  endtask

  // Called with inputs already set in the low clock phase; returns at the next negedge.
  task automatic step();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  int hi_a, hi_b, clr_a, clr_at;

  task automatic count_walk(input int budget, input int reinit_at);
    hi_a = 0; hi_b = 0; clr_a = 0; clr_at = -1;
    for (int k = 0; k < budget; k++) begin
      reinit = (k == reinit_at);
      if (bus_a.initializing_o) hi_a++;
      if (bus_b.initializing_o) hi_b++;
      if (bus_a.clear_rmr_o) begin clr_a++; clr_at = k; end
      if (!bus_a.initializing_o && !bus_b.initializing_o) break;
      step();
    end
    reinit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; reinit = 1'b0; tsk = '0; ntsk = '0; dbg = '0;
    rmr_a = 16'h0005; rmr_b = 12'h7FF; mpc_a = '0; mpc_b = '0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) begin m_val[d][i] = 1'b0; m_mem[d][i] = 0; end
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset initializing_a", 32'(bus_a.initializing_o), 1);
    chk("reset clear_rmr_a", 32'(bus_a.clear_rmr_o), 0);
    chk("reset dbg_mpc_a", 32'(bus_a.dbg_mpc_o), 0);
    rst = 1'b0;

    count_walk(40, -1);
    chk("walk_a_cycles", hi_a, 16);
    chk("walk_b_cycles", hi_b, 12);
    chk("walk_a_clear_pulses", clr_a, 1);
    chk("walk_a_clear_cycle", clr_at, 15);

    stall = 1'b1;
    dbg = 4'd0; step(); chk("dbg_a_entry0", 32'(bus_a.dbg_mpc_o), 32'h000);
    dbg = 4'd1; step(); chk("dbg_a_entry1", 32'(bus_a.dbg_mpc_o), 32'h401);
    dbg = 4'd2; step(); chk("dbg_a_entry2", 32'(bus_a.dbg_mpc_o), 32'h002);
    dbg = 4'd3; step(); chk("dbg_a_entry3", 32'(bus_a.dbg_mpc_o), 32'h403);
    dbg = 4'd11; step(); chk("dbg_b_entry11", 32'(bus_b.dbg_mpc_o), 32'h100B);

    stall = 1'b0; tsk = 4'd3; ntsk = 4'd3; mpc_a = 12'h123; mpc_b = 14'h0123;
    #1 chk("bypass_a", 32'(bus_a.mpc_o), 32'h123);
    step();
    tsk = 4'd2; ntsk = 4'd0; mpc_a = 12'h0AA; step();
    tsk = 4'd5; ntsk = 4'd2; mpc_a = 12'h055;
    #1 chk("task_switch_a", 32'(bus_a.mpc_o), 32'h0AA);
    step();

    stall = 1'b1; tsk = 4'd4; ntsk = 4'd4; mpc_a = 12'h777; dbg = 4'd4;
    #1 chk("stall_no_bypass_a", 32'(bus_a.mpc_o), 32'h404);
    step(); step();
    chk("stall_entry4_dbg_a", 32'(bus_a.dbg_mpc_o), 32'h404);
    stall = 1'b0; tsk = 4'd0; ntsk = 4'd4; mpc_a = 12'h000;
    #1 chk("stall_entry4_kept_a", 32'(bus_a.mpc_o), 32'h404);
    step();

    tsk = 4'd1; ntsk = 4'd13; dbg = 4'd14;
    #1 chk("oob_mpc_b", 32'(bus_b.mpc_o), 0);
    step();
    chk("oob_dbg_b", 32'(bus_b.dbg_mpc_o), 0);

    reinit = 1'b1; step(); reinit = 1'b0;
    count_walk(60, 7);
    chk("reinit_walk_a_cycles", hi_a, 24);
    chk("reinit_walk_a_clear_pulses", clr_a, 1);

    reinit = 1'b1; step(); reinit = 1'b0;
    repeat (9) step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_initializing_a", 32'(bus_a.initializing_o), 1);
    chk("async_rst_clear_rmr_a", 32'(bus_a.clear_rmr_o), 0);
    chk("async_rst_dbg_a", 32'(bus_a.dbg_mpc_o), 0);
    model_reset();
    step();
    rst = 1'b0;
    count_walk(40, -1);
    chk("post_rst_walk_a_cycles", hi_a, 16);
    chk("post_rst_walk_b_cycles", hi_b, 12);

    for (int c = 0; c < 3000; c++) begin
      stall  = ($urandom_range(0, 3) == 0);
      reinit = ($urandom_range(0, 96) == 0);
      tsk    = 4'($urandom_range(0, 15));
      ntsk   = ($urandom_range(0, 2) == 0) ? tsk : 4'($urandom_range(0, 15));
      dbg    = 4'($urandom_range(0, 15));
      mpc_a  = 12'($urandom);
      mpc_b  = 14'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        rmr_a = 16'($urandom);
        rmr_b = 12'($urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alto_task_mpc_bank.md
Name: alto_task_mpc_bank

Overview:
- Per-task micro-PC context store for the Alto microsequencer, generalised to any task count and PC width.
- Holds the saved MPC of every task.
- Supplies the MPC of the next task with same-task bypass.
- Runs a boot-time/warm-restart initialisation walk seeded from the reset-mode register (RMR).
- Adds what the fixed 16x12 version lacks: software-triggered reinit, non-power-of-two task counts, and a registered debug read port for the console/diagnostic path.

Parameters:
- NUM_TASKS, 16: number of task contexts (2..64, need not be a power of two).
- PC_WIDTH, 12: micro-PC width in bits.
- BANK_BIT, 10: bit position that receives ~rmr_i[task] in the boot MPC (must be < PC_WIDTH).
- BOOT_BASE, 0: PC_WIDTH-bit constant OR-ed into every boot MPC.
- TW (localparam), clog2(NUM_TASKS), min 1: task index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- rmr_i  in  NUM_TASKS  reset-mode register; bit t selects the boot bank for task t
- reinit_i  in  1  single-cycle warm-restart request
- clear_rmr_o  out  1  one-cycle pulse when the last entry is written by the walk
- initializing_o  out  1  high while the walk is in progress
- stall_i  in  1  pipeline stall; suppresses normal writes and bypass
- task_i  in  TW  currently executing task
- next_task_i  in  TW  task selected for the next cycle
- mpc_i  in  PC_WIDTH  next MPC of the current task
- mpc_o  out  PC_WIDTH  MPC to fetch for next_task_i
- dbg_task_i  in  TW  debug read index
- dbg_mpc_o  out  PC_WIDTH  registered debug read data

Behaviour:
- Storage: NUM_TASKS x PC_WIDTH array with one write port, combinational read at next_task_i, and one registered read at dbg_task_i. The array has no reset; its contents are defined only by the walk.
- Reset (async):
  - initializing_o=1, walk index=0, clear_rmr_o=0, dbg_mpc_o=0.
  - Walk starts on the first clock edge after rst_i deasserts.
- Walk:
  - Each cycle, entry[idx] <= BOOT_BASE | (~rmr_i[idx] << BANK_BIT) | idx, with idx zero-extended to PC_WIDTH.
  - stall_i is ignored during the walk; the walk always writes and always advances.
  - When idx == NUM_TASKS-1: that entry is written, clear_rmr_o=1 that cycle (combinational from idx and the walk flag), initializing_o falls at the following edge, and idx returns to 0.
  - Walk length is exactly NUM_TASKS cycles.
- clear_rmr_o is asserted only during the walk. It is never asserted when the idle index happens to equal NUM_TASKS-1.
- reinit_i:
  - When idle: initializing_o rises at the next edge and a full walk follows.
  - During a walk: the walk restarts at idx=0 at the next edge.
  - reinit_i coincident with the final walk cycle: the final write and the clear_rmr_o pulse still occur, then the walk restarts.
- Normal operation (initializing_o=0):
  - If !stall_i: entry[task_i] <= mpc_i.
  - If stall_i: no write.
- mpc_o selection:
  - If !initializing_o and task_i==next_task_i and !stall_i: mpc_o = mpc_i (bypass, zero latency).
  - Otherwise: mpc_o = entry[next_task_i].
  - During the walk, mpc_o is the stored value and is undefined for entries not yet written.
- Out-of-range indices (>= NUM_TASKS, non-power-of-two case):
  - Writes are dropped.
  - mpc_o and dbg_mpc_o read 0.
- Debug read: dbg_mpc_o <= entry[dbg_task_i] each cycle, giving 1-cycle latency. It returns old data when the same cycle writes that entry (read-before-write). It is not gated by stall_i.

Decomposition:
- Shared package alto_ctl_pkg holds:
  - clog2 function
  - default NUM_TASKS/PC_WIDTH/BANK_BIT constants
  - task index typedef
- Natural sub-module: alto_task_init_walker, containing the walk flag, index counter, terminal detect, clear_rmr_o and reinit restart.
- Array, bypass mux and debug port stay in the top module.

Test Plan:
- Defaults, rmr_i=16'h0005, reset released:
  - initializing_o is high for exactly 16 cycles.
  - clear_rmr_o pulses once, on the idx=15 cycle.
  - Debug reads return entry0=0x000, entry1=0x401, entry2=0x002, entry3=0x403.
- After init, task_i=next_task_i=3, mpc_i=0x123, stall_i=0 -> mpc_o=0x123 the same cycle.
- Task switch: write task 2 = 0x0AA, then next_task_i=2 with task_i=5 -> mpc_o=0x0AA.
- stall_i=1 with task_i=next_task_i=4, mpc_i=0x777 -> mpc_o=entry4 boot value (0x404 for rmr bit4=0), and entry4 is unchanged afterwards.
- reinit_i asserted at walk idx=7 -> walk restarts at 0, initializing_o stays high 8+16 cycles total, clear_rmr_o pulses exactly once.
- NUM_TASKS=12, PC_WIDTH=14, BANK_BIT=12:
  - Walk lasts 12 cycles and entry11 = (~rmr[11]<<12)|11.
  - next_task_i=13 -> mpc_o=0.
- Async reset mid-walk at idx=9 -> outputs return to reset values immediately, and the walk restarts from 0 after release.
